bp_be_dcache_trace_driver: RTL and testbench

Trace-driven stimulus source and response checker for the D$ test harness. It plays a command trace from a combinational trace ROM and issues dcache packets plus physical tags to the harness's packet port. It checks every in-order dcache response against the expected value queued at issue time. It is the initiator and consumer for the rolly-FIFO/dcache/ME stack, one instance per LCE.

---
 rtl/bp_be_dcache_trace_pkg.sv | 35 +++
 rtl/bsg_fifo_1r1w_small.sv | 45 ++++
 rtl/bp_be_dcache_trace_driver.sv | 129 ++++++++++++
 tb/tb_bp_be_dcache_trace_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_dcache_trace_pkg.sv
// Shared trace-driver types: command/state enums and the trace-entry struct macro.
`ifndef BP_BE_DCACHE_TRACE_PKG_SV
`define BP_BE_DCACHE_TRACE_PKG_SV

// dcache packet = {opcode[3:0], page_offset, data}
`define BP_BE_DCACHE_PKT_WIDTH(page_offset_width_mp, dword_width_mp) \
   (4 + (page_offset_width_mp) + (dword_width_mp))

`define DECLARE_BP_BE_DCACHE_TRACE_ENTRY_S(page_offset_width_mp, dword_width_mp, ptag_width_mp) \
   typedef struct packed { \
      bp_trace_cmd_e                                                          cmd; \
      logic                                                                   check; \
      logic [`BP_BE_DCACHE_PKT_WIDTH(page_offset_width_mp, dword_width_mp)-1:0] pkt; \
      logic [(ptag_width_mp)-1:0]                                             ptag; \
      logic [(dword_width_mp)-1:0]                                            expected; \
   } bp_be_dcache_trace_entry_s

package bp_be_dcache_trace_pkg;

   typedef enum logic [1:0] {
      e_trace_send  = 2'b00,
      e_trace_wait  = 2'b01,
      e_trace_delay = 2'b10,
      e_trace_done  = 2'b11
   } bp_trace_cmd_e;

   typedef enum logic [1:0] {
      e_run,
      e_delay,
      e_done
   } bp_trace_state_e;

endpackage

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO, valid/ready in, valid/yumi out.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 65,
   parameter int els_p   = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);
   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

   logic [width_p-1:0]  mem [els_p];
   logic [ptr_w_lp-1:0] rptr_r, wptr_r;
   logic [ptr_w_lp:0]   cnt_r;
   logic                enq, deq;

   assign ready_o = (cnt_r != (ptr_w_lp+1)'(els_p));
   assign v_o     = (cnt_r != '0);
   assign data_o  = mem[rptr_r];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rptr_r <= '0;
         wptr_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (enq) wptr_r <= (wptr_r == ptr_w_lp'(els_p-1)) ? '0 : wptr_r + 1'b1;
         if (deq) rptr_r <= (rptr_r == ptr_w_lp'(els_p-1)) ? '0 : rptr_r + 1'b1;
         if (enq & ~deq)      cnt_r <= cnt_r + 1'b1;
         else if (deq & ~enq) cnt_r <= cnt_r - 1'b1;
      end
   end

   // storage needs no reset; occupancy is tracked by cnt_r
   always_ff @(posedge clk_i) begin
      if (enq) mem[wptr_r] <= data_i;
   end
endmodule

// File: rtl/bp_be_dcache_trace_driver.sv
// Plays a trace ROM into the dcache harness and checks in-order responses.
module bp_be_dcache_trace_driver
   import bp_be_dcache_trace_pkg::*;
#(
   parameter int dword_width_p       = 64,
   parameter int page_offset_width_p = 12,
   parameter int ptag_width_p        = 28,
   parameter int trace_els_p         = 256,
   parameter int outstanding_els_p   = 8,
   parameter int err_cnt_width_p     = 16,
   localparam int dcache_pkt_width_lp = `BP_BE_DCACHE_PKT_WIDTH(page_offset_width_p, dword_width_p),
   localparam int trace_width_lp      = 2 + 1 + dcache_pkt_width_lp + ptag_width_p + dword_width_p,
   localparam int rom_addr_width_lp   = $clog2(trace_els_p)
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   output logic [rom_addr_width_lp-1:0]   rom_addr_o,
   input  logic [trace_width_lp-1:0]      rom_data_i,
   output logic [dcache_pkt_width_lp-1:0] dcache_pkt_o,
   output logic [ptag_width_p-1:0]        ptag_o,
   output logic                           dcache_pkt_v_o,
   input  logic                           dcache_pkt_ready_i,
   input  logic                           v_i,
   input  logic [dword_width_p-1:0]       data_i,
   output logic                           done_o,
   output logic                           error_o,
   output logic [err_cnt_width_p-1:0]     err_cnt_o
);
   localparam int cnt_width_lp = $clog2(outstanding_els_p+1);

   `DECLARE_BP_BE_DCACHE_TRACE_ENTRY_S(page_offset_width_p, dword_width_p, ptag_width_p);

   bp_be_dcache_trace_entry_s entry;
   bp_trace_cmd_e             cmd;
   bp_trace_state_e           state_r, state_n;
   logic [rom_addr_width_lp-1:0] pc_r, pc_n;
   logic [cnt_width_lp-1:0]      cnt_r;
   logic [15:0]                  delay_r, delay_n;
   logic                         end_r, end_n;
   logic                         pkt_v, advance, xfer, push, pop, err_inc;
   logic                         fifo_ready, head_v, head_check;
   logic [dword_width_p-1:0]     head_expected;

   assign entry        = rom_data_i;
   // past the last ROM entry the trace behaves as an implicit DONE
   assign cmd          = end_r ? e_trace_done : entry.cmd;
   assign rom_addr_o   = pc_r;
   assign dcache_pkt_o = entry.pkt;
   assign ptag_o       = entry.ptag;
   assign dcache_pkt_v_o = pkt_v;
   assign done_o       = (state_r == e_done);

   always_comb begin
      state_n = state_r;
      pc_n    = pc_r;
      end_n   = end_r;
      delay_n = delay_r;
      pkt_v   = 1'b0;
      advance = 1'b0;
      case (state_r)
         e_run: begin
            case (cmd)
               e_trace_send:  begin
                  pkt_v   = (cnt_r < cnt_width_lp'(outstanding_els_p));
                  advance = pkt_v & dcache_pkt_ready_i;
               end
               e_trace_wait:  advance = (cnt_r == '0);
               e_trace_delay: begin
                  advance = 1'b1;
                  delay_n = entry.expected[15:0];
                  state_n = e_delay;
               end
               default:       if (cnt_r == '0) state_n = e_done;
            endcase
            if (advance) begin
               if (pc_r == rom_addr_width_lp'(trace_els_p-1)) end_n = 1'b1;
               else                                           pc_n  = pc_r + 1'b1;
            end
         end
         e_delay: begin
            if (delay_r == '0) state_n = e_run;
            else               delay_n = delay_r - 1'b1;
         end
         default: ;
      endcase
   end

   assign xfer    = pkt_v & dcache_pkt_ready_i;
   assign push    = xfer & fifo_ready;
   assign pop     = v_i & head_v;
   assign err_inc = v_i & (~head_v | (head_check & (data_i != head_expected)));

   bsg_fifo_1r1w_small #(
      .width_p (1 + dword_width_p),
      .els_p   (outstanding_els_p)
   ) expected_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (push),
      .ready_o (fifo_ready),
      .data_i  ({entry.check, entry.expected}),
      .v_o     (head_v),
      .data_o  ({head_check, head_expected}),
      .yumi_i  (pop)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r   <= e_run;
         pc_r      <= '0;
         end_r     <= 1'b0;
         delay_r   <= '0;
         cnt_r     <= '0;
         error_o   <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         state_r <= state_n;
         pc_r    <= pc_n;
         end_r   <= end_n;
         delay_r <= delay_n;
         if (push & ~pop)      cnt_r <= cnt_r + 1'b1;
         else if (pop & ~push) cnt_r <= cnt_r - 1'b1;
         if (err_inc) begin
            error_o <= 1'b1;
            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bp_be_dcache_trace_driver.sv
// Directed bench for the dcache trace driver with hand-computed expectations.
module tb_bp_be_dcache_trace_driver;
   localparam int PW = 4 + 12 + 64;
   localparam int TW = 2 + 1 + PW + 28 + 64;
   localparam logic [1:0] C_SEND = 2'b00, C_WAIT = 2'b01, C_DELAY = 2'b10, C_DONE = 2'b11;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic [7:0]    rom_addr;
   logic [TW-1:0] rom_data;
   logic [PW-1:0] dcache_pkt;
   logic [27:0]   ptag;
   logic          pkt_v;
   logic          pkt_ready = 1'b0;
   logic          v_i = 1'b0;
   logic [63:0]   data_i = '0;
   logic          done;
   logic          error;
   logic [15:0]   err_cnt;

   logic [TW-1:0] rom [256];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   assign rom_data = rom[rom_addr];

   bp_be_dcache_trace_driver dut (
      .clk_i              (clk),
      .reset_i            (reset_i),
      .rom_addr_o         (rom_addr),
      .rom_data_i         (rom_data),
      .dcache_pkt_o       (dcache_pkt),
      .ptag_o             (ptag),
      .dcache_pkt_v_o     (pkt_v),
      .dcache_pkt_ready_i (pkt_ready),
      .v_i                (v_i),
      .data_i             (data_i),
      .done_o             (done),
      .error_o            (error),
      .err_cnt_o          (err_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] mkpkt(input logic [27:0] pt, input logic [63:0] ex);
      return {4'h2, pt[11:0], ex};
   endfunction

   function automatic logic [TW-1:0] mk(input logic [1:0] c, input logic ck,
                                        input logic [27:0] pt, input logic [63:0] ex);
      return {c, ck, mkpkt(pt, ex), pt, ex};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = mk(C_DONE, 1'b0, 28'h0, 64'h0);
   endtask

   task automatic do_reset();
      v_i = 1'b0;
      pkt_ready = 1'b0;
      reset_i = 1'b1;
      #1;
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_err_cnt", err_cnt, 16'h0);
      chk("rst_addr", rom_addr, 8'h0);
      tick();
      reset_i = 1'b0;
   endtask

   initial begin
      int n;
      // single load with matching response
      clear_rom();
      rom[0] = mk(C_SEND, 1'b1, 28'h8000, 64'hDEAD_BEEF);
      do_reset();
      pkt_ready = 1'b1;
      #1;
      chk("t1_v", pkt_v, 1'b1);
      chk("t1_ptag", ptag, 28'h8000);
      chk("t1_pkt", dcache_pkt, mkpkt(28'h8000, 64'hDEAD_BEEF));
      tick();
      chk("t1_addr", rom_addr, 8'h1);
      chk("t1_v_done", pkt_v, 1'b0);
      repeat (4) tick();
      chk("t1_not_done", done, 1'b0);
      v_i = 1'b1; data_i = 64'hDEAD_BEEF;
      tick();
      v_i = 1'b0;
      chk("t1_err", error, 1'b0);
      chk("t1_done_early", done, 1'b0);
      tick();
      chk("t1_done", done, 1'b1);
      chk("t1_err_cnt", err_cnt, 16'h0);

      // mismatch
      clear_rom();
      rom[0] = mk(C_SEND, 1'b1, 28'h1234, 64'h1);
      do_reset();
      pkt_ready = 1'b1;
      tick();
      tick();
      v_i = 1'b1; data_i = 64'h2;
      #1;
      chk("t2_cnt_before", err_cnt, 16'h0);
      tick();
      v_i = 1'b0;
      chk("t2_cnt", err_cnt, 16'h1);
      chk("t2_error", error, 1'b1);
      tick();
      chk("t2_done", done, 1'b1);
      chk("t2_cnt_hold", err_cnt, 16'h1);
      chk("t2_error_hold", error, 1'b1);

      // backpressure / full
      clear_rom();
      for (int i = 0; i < 10; i++) rom[i] = mk(C_SEND, 1'b0, 28'(i), 64'(i));
      do_reset();
      pkt_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (pkt_v & pkt_ready) n++;
         tick();
      end
      chk("t3_xfers", n, 8);
      chk("t3_v_full", pkt_v, 1'b0);
      chk("t3_addr_full", rom_addr, 8'h8);
      v_i = 1'b1;
      #1;
      chk("t3_v_pop_cycle", pkt_v, 1'b0);
      tick();
      v_i = 1'b0;
      #1;
      chk("t3_v_after_pop", pkt_v, 1'b1);
      tick();
      chk("t3_v_refull", pkt_v, 1'b0);
      chk("t3_addr_after", rom_addr, 8'h9);
      chk("t3_err_cnt", err_cnt, 16'h0);

      // WAIT / DELAY
      clear_rom();
      rom[0] = mk(C_SEND, 1'b1, 28'h11, 64'h5);
      rom[1] = mk(C_WAIT, 1'b0, 28'h0, 64'h0);
      rom[2] = mk(C_DELAY, 1'b0, 28'h0, 64'h3);
      rom[3] = mk(C_SEND, 1'b1, 28'h22, 64'h7);
      do_reset();
      pkt_ready = 1'b1;
      tick();
      tick(); tick();
      chk("t4_wait_addr", rom_addr, 8'h1);
      chk("t4_wait_v", pkt_v, 1'b0);
      v_i = 1'b1; data_i = 64'h5;
      tick();
      v_i = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (pkt_v) n++;
         tick();
      end
      chk("t4_early_v", n, 0);
      chk("t4_v", pkt_v, 1'b1);
      chk("t4_addr", rom_addr, 8'h3);
      chk("t4_ptag", ptag, 28'h22);
      tick();
      v_i = 1'b1; data_i = 64'h7;
      tick();
      v_i = 1'b0;
      tick();
      chk("t4_done", done, 1'b1);
      chk("t4_err_cnt", err_cnt, 16'h0);

      // unexpected response with empty queue must not disturb cnt
      clear_rom();
      rom[0] = mk(C_DELAY, 1'b0, 28'h0, 64'h2);
      rom[1] = mk(C_WAIT, 1'b0, 28'h0, 64'h0);
      do_reset();
      tick();
      v_i = 1'b1; data_i = 64'h9;
      tick();
      v_i = 1'b0;
      chk("t5_err_cnt", err_cnt, 16'h1);
      chk("t5_error", error, 1'b1);
      n = 0;
      while (!done && n < 10) begin
         tick();
         n++;
      end
      chk("t5_done", done, 1'b1);
      chk("t5_addr", rom_addr, 8'h2);
      chk("t5_err_cnt_end", err_cnt, 16'h1);

      // reset mid-run
      clear_rom();
      for (int i = 0; i < 10; i++) rom[i] = mk(C_SEND, 1'b1, 28'(16'h100 + i), 64'(i));
      do_reset();
      pkt_ready = 1'b1;
      tick(); tick(); tick();
      chk("t6_addr_pre", rom_addr, 8'h3);
      v_i = 1'b1; data_i = 64'hBAD;
      #1;
      reset_i = 1'b1;
      #1;
      v_i = 1'b0;
      chk("t6_addr_rst", rom_addr, 8'h0);
      chk("t6_err_rst", err_cnt, 16'h0);
      chk("t6_error_rst", error, 1'b0);
      chk("t6_done_rst", done, 1'b0);
      tick();
      reset_i = 1'b0;
      #1;
      chk("t6_reissue_v", pkt_v, 1'b1);
      chk("t6_reissue_ptag", ptag, 28'h100);
      tick();
      chk("t6_addr_post", rom_addr, 8'h1);

      // end of trace: no wrap, implicit DONE
      for (int i = 0; i < 255; i++) rom[i] = mk(C_WAIT, 1'b0, 28'h0, 64'h0);
      rom[255] = mk(C_SEND, 1'b0, 28'h3FF, 64'h0);
      do_reset();
      pkt_ready = 1'b1;
      repeat (255) tick();
      chk("t7_addr_last", rom_addr, 8'hFF);
      chk("t7_v_last", pkt_v, 1'b1);
      tick();
      chk("t7_v_end", pkt_v, 1'b0);
      chk("t7_addr_end", rom_addr, 8'hFF);
      chk("t7_drain", done, 1'b0);
      v_i = 1'b1; data_i = 64'h0;
      tick();
      v_i = 1'b0;
      tick();
      chk("t7_done", done, 1'b1);
      chk("t7_addr_hold", rom_addr, 8'hFF);
      chk("t7_err_cnt", err_cnt, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
